riscv_hpm_counters: RTL and testbench

- Machine counter/timer bank: mcycle, minstret and NB_HPM event counters (mhpmcounter3..), plus mcountinhibit and mcounteren.
- Sits beside the CSR unit. It decodes its own CSR address slice, returns read data one cycle after the request and flags illegal accesses.
- Counts per-cycle event increments from the core; each increment can be greater than 1 for multi-issue retire.

---
 rtl/riscv_hpm_counters_pkg.sv | 34 +++
 rtl/riscv_hpm_counters_hpm_counter.sv | 43 ++++
 rtl/riscv_hpm_counters.sv | 161 ++++++++++++++++
 tb/tb_riscv_hpm_counters.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_hpm_counters_pkg.sv
// CSR addresses, privilege encoding and the counter-position mask shared by the HPM counter bank.
// Position layout everywhere: bit0 cycle, bit1 unused (time), bit2 instret, bit3+k event counter k.
package riscv_hpm_counters_pkg;

    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPM_BASE     = 12'hB03;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHPMH_BASE    = 12'hB83;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_HPMOVF        = 12'h7C0;

    localparam int NB_HPM = 14;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_lvl_t;

    // Positions that hold a real counter for a given number of event counters.
    function automatic logic [31:0] cnt_mask(input int nb);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int i = 0; i < 29; i++) begin
            if (i < nb) m[3+i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/riscv_hpm_counters_hpm_counter.sv
// One counter: per-cycle increment when enabled, XLEN-wide low/high writes, wrap pulse on carry-out.
// A write to either half takes priority over the increment in the same cycle.
module hpm_counter #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64,
    parameter int INC_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en_i,
    input  logic [INC_WIDTH-1:0] inc_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [XLEN-1:0]      wdata_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 wrap_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH:0]   sum;

    always_comb begin
        sum    = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc_i);
        cnt_d  = cnt_q;
        wrap_o = 1'b0;
        if (wr_lo_i) begin
            cnt_d[XLEN-1:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[CNT_WIDTH-1:XLEN] = wdata_i[CNT_WIDTH-XLEN-1:0];
        end else if (en_i) begin
            cnt_d  = sum[CNT_WIDTH-1:0];
            wrap_o = sum[CNT_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/riscv_hpm_counters.sv
// Machine counter bank (mcycle/minstret/mhpmcounterN) with its own CSR decode; read data and illegal flag one cycle after request.
// No backpressure. Optional overflow status CSR 0x7C0 and irq under RISCV_HPM_OVF_IRQ_EN.
module riscv_hpm_counters #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64,
    parameter int NB_HPM    = riscv_hpm_counters_pkg::NB_HPM,
    parameter int INC_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        csr_rd_en_i,
    input  logic                        csr_wr_en_i,
    input  logic [11:0]                 csr_addr_i,
    input  logic [XLEN-1:0]             csr_wdata_i,
    input  logic [1:0]                  priv_i,
    input  logic                        halt_i,
    input  logic [INC_WIDTH-1:0]        retire_cnt_i,
    input  logic [NB_HPM*INC_WIDTH-1:0] event_inc_i,
    output logic                        csr_hit_o,
    output logic                        csr_rvalid_o,
    output logic [XLEN-1:0]             csr_rdata_o,
    output logic                        csr_illegal_o,
    output logic                        irq_ovf_o
);

    import riscv_hpm_counters_pkg::*;

    localparam logic [31:0] IMPL_MASK = cnt_mask(NB_HPM);

    logic [CNT_WIDTH-1:0] cnt [32];
    logic [31:0]          wrap_vec;
    logic [31:0]          mcountinhibit_q, mcountinhibit_d;
    logic [31:0]          mcounteren_q, mcounteren_d;
    logic [31:0]          ovf_rd;
    logic                 rvalid_q, rvalid_d, illegal_q, illegal_d;
    logic [XLEN-1:0]      rdata_q, rdata_d, rsel;

    logic [4:0] idx;
    logic       is_cnt, is_shadow, is_hi, is_inh, is_en, is_ovf;
    logic       m_mode, rd_legal, wr_legal, wr_ok, wr_cnt;

    assign idx       = csr_addr_i[4:0];
    assign is_hi     = csr_addr_i[7];
    assign is_shadow = (csr_addr_i[11:8] == 4'hC);
    // 0x?01 / 0x?81 would be the time CSR, which lives elsewhere.
    assign is_cnt    = ((csr_addr_i[11:8] == 4'hB) || is_shadow) && (csr_addr_i[6:5] == 2'b00)
                       && (idx != 5'd1);
    assign is_inh    = (csr_addr_i == CSR_MCOUNTINHIBIT);
    assign is_en     = (csr_addr_i == CSR_MCOUNTEREN);
    assign csr_hit_o = is_cnt || is_inh || is_en || is_ovf;

    assign m_mode   = (priv_i == PRIV_M);
    assign rd_legal = m_mode || (is_cnt && is_shadow && mcounteren_q[idx]);
    assign wr_legal = m_mode && !(is_cnt && is_shadow);
    assign wr_ok    = csr_wr_en_i && csr_hit_o && wr_legal;
    assign wr_cnt   = wr_ok && is_cnt;

    for (genvar p = 0; p < 32; p++) begin : g_cnt
        if (IMPL_MASK[p]) begin : g_impl
            logic [INC_WIDTH-1:0] inc;
            if (p == 0) begin : g_cy
                assign inc = INC_WIDTH'(1);
            end else if (p == 2) begin : g_ir
                assign inc = retire_cnt_i;
            end else begin : g_ev
                assign inc = event_inc_i[(p-3)*INC_WIDTH +: INC_WIDTH];
            end
            hpm_counter #(
                .XLEN      (XLEN),
                .CNT_WIDTH (CNT_WIDTH),
                .INC_WIDTH (INC_WIDTH)
            ) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .en_i    (!halt_i && !mcountinhibit_q[p]),
                .inc_i   (inc),
                .wr_lo_i (wr_cnt && !is_hi && (idx == 5'(p))),
                .wr_hi_i (wr_cnt && is_hi && (idx == 5'(p))),
                .wdata_i (csr_wdata_i),
                .cnt_o   (cnt[p]),
                .wrap_o  (wrap_vec[p])
            );
        end else begin : g_none
            assign cnt[p]      = '0;
            assign wrap_vec[p] = 1'b0;
        end
    end

`ifdef RISCV_HPM_OVF_IRQ_EN
    logic [31:0] ovf_q, ovf_d;
    logic        irq_q, irq_d;

    assign is_ovf = (csr_addr_i == CSR_HPMOVF);

    // Clear-by-writing-1 is applied first so a wrap in the same cycle re-sets the bit.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_ok && is_ovf) ovf_d = ovf_q & ~csr_wdata_i[31:0];
        ovf_d = ovf_d | wrap_vec;
        irq_d = |ovf_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= irq_d;
        end
    end

    assign ovf_rd    = ovf_q;
    assign irq_ovf_o = irq_q;
`else
    logic unused_wrap;
    assign unused_wrap = ^wrap_vec;
    assign is_ovf      = 1'b0;
    assign ovf_rd      = '0;
    assign irq_ovf_o   = 1'b0;
`endif

    always_comb begin
        rsel = '0;
        if (is_cnt)      rsel = is_hi ? XLEN'(cnt[idx][CNT_WIDTH-1:XLEN]) : cnt[idx][XLEN-1:0];
        else if (is_inh) rsel = XLEN'(mcountinhibit_q);
        else if (is_en)  rsel = XLEN'(mcounteren_q);
        else if (is_ovf) rsel = XLEN'(ovf_rd);
    end

    always_comb begin
        mcountinhibit_d = mcountinhibit_q;
        mcounteren_d    = mcounteren_q;
        if (wr_ok && is_inh) mcountinhibit_d = csr_wdata_i[31:0] & IMPL_MASK;
        if (wr_ok && is_en)  mcounteren_d    = csr_wdata_i[31:0] & IMPL_MASK;
        rvalid_d  = csr_rd_en_i && csr_hit_o;
        illegal_d = (rvalid_d && !rd_legal) || (csr_wr_en_i && csr_hit_o && !wr_legal);
        rdata_d   = (rvalid_d && rd_legal) ? rsel : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcountinhibit_q <= '0;
            mcounteren_q    <= '0;
            rvalid_q        <= 1'b0;
            illegal_q       <= 1'b0;
            rdata_q         <= '0;
        end else begin
            mcountinhibit_q <= mcountinhibit_d;
            mcounteren_q    <= mcounteren_d;
            rvalid_q        <= rvalid_d;
            illegal_q       <= illegal_d;
            rdata_q         <= rdata_d;
        end
    end

    assign csr_rvalid_o  = rvalid_q;
    assign csr_illegal_o = illegal_q;
    assign csr_rdata_o   = rdata_q;

endmodule

// File: tb/tb_riscv_hpm_counters.sv
// Scoreboarded bench for the HPM counter bank against a cycle-level arithmetic model.
module tb_riscv_hpm_counters;

    localparam int NB = 14;
    localparam bit [1:0] PM = 2'b11;
    localparam bit [1:0] PU = 2'b00;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        csr_rd_en_i = 1'b0, csr_wr_en_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [1:0]  priv_i = PM;
    logic        halt_i = 1'b0;
    logic [1:0]  retire_cnt_i = '0;
    logic [27:0] event_inc_i = '0;
    logic        csr_hit_o, csr_rvalid_o, csr_illegal_o, irq_ovf_o;
    logic [31:0] csr_rdata_o;

    riscv_hpm_counters dut (
        .clk(clk), .reset_n(reset_n), .csr_rd_en_i(csr_rd_en_i), .csr_wr_en_i(csr_wr_en_i),
        .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .priv_i(priv_i), .halt_i(halt_i),
        .retire_cnt_i(retire_cnt_i), .event_inc_i(event_inc_i), .csr_hit_o(csr_hit_o),
        .csr_rvalid_o(csr_rvalid_o), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
        .irq_ovf_o(irq_ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        vld;
        bit        ill;
        bit [31:0] data;
    } exp_t;

    exp_t      exp_q[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    bit [63:0] m_cnt [32];
    bit [31:0] m_inh, m_en, m_ovf;
    bit        m_irq;

    function automatic bit impl(int p);
        return (p == 0) || (p == 2) || (p >= 3 && p < 3 + NB);
    endfunction

    function automatic bit [31:0] impl_mask();
        bit [31:0] m = 0;
        for (int p = 0; p < 32; p++) if (impl(p)) m[p] = 1'b1;
        return m;
    endfunction

    function automatic bit is_cnt_addr(int a);
        bit in_rng = (a >= 'hB00 && a <= 'hB1F) || (a >= 'hB80 && a <= 'hB9F) ||
                     (a >= 'hC00 && a <= 'hC1F) || (a >= 'hC80 && a <= 'hC9F);
        return in_rng && ((a % 32) != 1);
    endfunction

    function automatic bit model_hit(int a);
        bit ovf_csr = 1'b0;
`ifdef RISCV_HPM_OVF_IRQ_EN
        ovf_csr = (a == 'h7C0);
`endif
        return is_cnt_addr(a) || a == 'h306 || a == 'h320 || ovf_csr;
    endfunction

    function automatic bit [31:0] model_val(int a);
        bit [63:0] v;
        if (is_cnt_addr(a)) begin
            v = impl(a % 32) ? m_cnt[a % 32] : 64'd0;
            return (a % 256 >= 'h80) ? v[63:32] : v[31:0];
        end
        if (a == 'h306) return m_en;
        if (a == 'h320) return m_inh;
        return m_ovf;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 32; p++) m_cnt[p] = 0;
        m_inh = 0; m_en = 0; m_ovf = 0; m_irq = 0;
    endtask

    // Drives one cycle starting at a falling edge; records the expected response and advances the model.
    task automatic step(input bit rd, input bit wr, input bit [11:0] addr, input bit [31:0] wd,
                        input bit [1:0] priv, input bit halt, input bit [1:0] ret, input bit [27:0] ev);
        exp_t      e;
        bit        hit, shadow, rd_ok, wr_ok;
        bit [31:0] written, wraps, clr, n_inh, n_en;
        bit [63:0] n_cnt [32];
        bit [64:0] sum;
        int        a, p;
        csr_rd_en_i = rd; csr_wr_en_i = wr; csr_addr_i = addr; csr_wdata_i = wd;
        priv_i = priv; halt_i = halt; retire_cnt_i = ret; event_inc_i = ev;
        a      = int'(addr);
        hit    = model_hit(a);
        shadow = (a >= 'hC00 && a <= 'hCFF);
        rd_ok  = (priv == PM) || (shadow && m_en[a % 32]);
        wr_ok  = (priv == PM) && !shadow;
        e.vld  = rd && hit;
        e.ill  = (rd && hit && !rd_ok) || (wr && hit && !wr_ok);
        e.data = (rd && hit && rd_ok) ? model_val(a) : 32'd0;
        if (e.vld || e.ill) exp_q.push_back(e);

        written = 0; wraps = 0; clr = 0; n_inh = m_inh; n_en = m_en;
        for (int i = 0; i < 32; i++) n_cnt[i] = m_cnt[i];
        if (wr && hit && wr_ok) begin
            if (is_cnt_addr(a)) begin
                p = a % 32;
                if (impl(p)) begin
                    if (a % 256 >= 'h80) n_cnt[p][63:32] = wd;
                    else                 n_cnt[p][31:0]  = wd;
                    written[p] = 1'b1;
                end
            end else if (a == 'h320) n_inh = wd & impl_mask();
            else if (a == 'h306)     n_en  = wd & impl_mask();
            else                     clr   = wd;
        end
        for (int i = 0; i < 32; i++) begin
            if (impl(i) && !written[i] && !halt && !m_inh[i]) begin
                sum = {1'b0, m_cnt[i]} + ((i == 0) ? 65'd1 : (i == 2) ? 65'(ret) : 65'(ev[(i-3)*2 +: 2]));
                n_cnt[i] = sum[63:0];
                wraps[i] = sum[64];
            end
        end
        @(posedge clk);
        for (int i = 0; i < 32; i++) m_cnt[i] = n_cnt[i];
        m_inh = n_inh; m_en = n_en;
`ifdef RISCV_HPM_OVF_IRQ_EN
        m_ovf = (m_ovf & ~clr) | wraps;
`endif
        m_irq = |m_ovf;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 12'h000, 0, PM, 0, 0, 0);
    endtask

    task automatic rd_m(input bit [11:0] addr);
        step(1, 0, addr, 0, PM, 0, 0, 0);
    endtask

    task automatic wr_m(input bit [11:0] addr, input bit [31:0] wd);
        step(0, 1, addr, wd, PM, 0, 0, 0);
    endtask

    task automatic check(input string name, input bit [31:0] act, input bit [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    // Response monitor, decoupled from stimulus.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (csr_rvalid_o || csr_illegal_o) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: vld=%0b ill=%0b data=0x%08h, none expected",
                             csr_rvalid_o, csr_illegal_o, csr_rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    if (csr_rvalid_o !== e.vld || csr_illegal_o !== e.ill || csr_rdata_o !== e.data) begin
                        n_fail++;
                        $display("FAIL rsp: got vld=%0b ill=%0b data=0x%08h, want vld=%0b ill=%0b data=0x%08h",
                                 csr_rvalid_o, csr_illegal_o, csr_rdata_o, e.vld, e.ill, e.data);
                    end
                end
            end
            n_tests++;
            if (irq_ovf_o !== m_irq) begin
                n_fail++;
                $display("FAIL irq_ovf: got %0b, want %0b", irq_ovf_o, m_irq);
            end
        end
    end

    initial begin
        bit [11:0] alist [21];
        bit [31:0] wd;
        alist = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB10, 12'hB11, 12'hB1F, 12'hB80, 12'hB82,
                  12'hB83, 12'hC00, 12'hC02, 12'hC03, 12'hC80, 12'hC83, 12'hC01, 12'hB01,
                  12'h306, 12'h320, 12'h7C0, 12'h123};
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_rvalid", 32'(csr_rvalid_o), 0);
        check("reset_illegal", 32'(csr_illegal_o), 0);
        check("reset_rdata", csr_rdata_o, 0);
        check("reset_irq", 32'(irq_ovf_o), 0);
        reset_n = 1'b1;

        idle(10);
        rd_m(12'hB00);
        rd_m(12'hB02);

        wr_m(12'hB80, 32'h1);
        wr_m(12'hB00, 32'hFFFF_FFFE);
        rd_m(12'hB00);
        idle(1);
        rd_m(12'hB80);

        wr_m(12'h320, 32'h8);
        repeat (5) step(0, 0, 12'h000, 0, PM, 0, 0, 28'h2);
        rd_m(12'hB03);
        wr_m(12'h320, 32'h0);
        repeat (5) step(0, 0, 12'h000, 0, PM, 0, 0, 28'h2);
        rd_m(12'hB03);

        step(1, 0, 12'hC00, 0, PU, 0, 0, 0);
        wr_m(12'h306, 32'h1);
        step(1, 0, 12'hC00, 0, PU, 0, 0, 0);
        step(1, 0, 12'hC02, 0, PU, 0, 0, 0);
        step(0, 1, 12'hC00, 32'h5, PU, 0, 0, 0);
        wr_m(12'hC00, 32'h7);
        step(1, 0, 12'hB00, 0, PU, 0, 0, 0);
        rd_m(12'hC00);

        step(1, 1, 12'hB02, 32'h55, PM, 0, 2'd2, 0);
        rd_m(12'hB02);
        repeat (3) step(0, 0, 12'h000, 0, PM, 1, 2'd3, 28'hFFF_FFFF);
        rd_m(12'hB00);
        rd_m(12'hB11);
        wr_m(12'hB11, 32'h1234);
        rd_m(12'hB11);

        wr_m(12'hB83, 32'hFFFF_FFFF);
        wr_m(12'hB03, 32'hFFFF_FFFF);
        step(0, 0, 12'h000, 0, PM, 0, 0, 28'h2);
        idle(1);
        rd_m(12'hB03);
        rd_m(12'h7C0);
        wr_m(12'h7C0, 32'h8);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, alist[$urandom_range(0, 20)], wd,
                 ($urandom_range(0, 3) == 0) ? PU : PM, $urandom_range(0, 9) == 0,
                 2'($urandom_range(0, 3)), 28'($urandom));
        end
        idle(2);

        csr_rd_en_i = 1'b1; csr_addr_i = 12'hB00;
        #2 reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        csr_rd_en_i = 1'b0;
        #1 check("rst_drop_rvalid", 32'(csr_rvalid_o), 0);
        @(negedge clk);
        check("rst_irq", 32'(irq_ovf_o), 0);
        reset_n = 1'b1;
        idle(3);
        rd_m(12'hB00);
        rd_m(12'hB03);
        rd_m(12'h320);
        idle(2);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
